frame_buffer_sink: RTL and testbench

FRAME_BUFFER_SINK -- requirements
Module: frame_buffer_sink

---
 rtl/frame_buffer_sink.sv | 107 ++++++++++
 tb/tb_frame_buffer_sink.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_sink.sv
// Double-buffered 64x64 pixel store for a 1:32 scan LED panel.
// The writer fills the back bank; a write to the last pixel (63,63) arms a
// bank swap that is taken at the next frame_sync. Each read returns the top
// half pixel (row) and bottom half pixel (row+32) of the front bank together.
module frame_buffer_sink #(
  parameter int COLOR_W = 9
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               write_en,
  input  logic [5:0]         write_x,
  input  logic [5:0]         write_y,
  input  logic [COLOR_W-1:0] write_color,
  input  logic               frame_sync,
  input  logic               rd_en,
  input  logic [5:0]         rd_x,
  input  logic [4:0]         rd_row,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_top,
  output logic [COLOR_W-1:0] rd_bot,
  output logic               front_bank,
  output logic               swap_pending
);

  localparam int DEPTH = 2048;

  // Index 0/1 selects the bank; rows 0-31 live in memTop, rows 32-63 in memBot
  logic [COLOR_W-1:0] memTop [2][DEPTH];
  logic [COLOR_W-1:0] memBot [2][DEPTH];

  logic               frontBank_q, frontBank_d;
  logic               swapPending_q, swapPending_d;
  logic               rdValid_q;
  logic [COLOR_W-1:0] rdTop_q;
  logic [COLOR_W-1:0] rdBot_q;

  logic [10:0]        wrAddr;
  logic [10:0]        rdAddr;
  logic               wrBank;
  logic               lastPixel;

  assign wrAddr    = {write_y[4:0], write_x};
  assign rdAddr    = {rd_row, rd_x};
  assign wrBank    = ~frontBank_q;
  assign lastPixel = write_en && (write_x == 6'd63) && (write_y == 6'd63);

  // Swap control: a sync swaps if a frame is waiting or completes this cycle,
  // otherwise finishing the frame just marks it as waiting
  always_comb begin
    frontBank_d   = frontBank_q;
    swapPending_d = swapPending_q;
    if (frame_sync && (swapPending_q || lastPixel)) begin
      frontBank_d   = ~frontBank_q;
      swapPending_d = 1'b0;
    end else if (lastPixel) begin
      swapPending_d = 1'b1;
    end
  end

  // Bank-select and pending-frame state
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frontBank_q   <= 1'b0;
      swapPending_q <= 1'b0;
    end else begin
      frontBank_q   <= frontBank_d;
      swapPending_q <= swapPending_d;
    end
  end

  // Pixel writes always go to the bank that is back before this edge; contents
  // survive reset, but writes are ignored while reset is held
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (rst_n) begin
      if (write_en) begin
        if (write_y[5]) begin
          memBot[wrBank][wrAddr] <= write_color;
        end else begin
          memTop[wrBank][wrAddr] <= write_color;
        end
      end
    end
  end

  // One-cycle read of both panel halves from the current front bank; data
  // holds its last value on idle cycles
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rdValid_q <= 1'b0;
      rdTop_q   <= '0;
      rdBot_q   <= '0;
    end else begin
      rdValid_q <= rd_en;
      if (rd_en) begin
        rdTop_q <= memTop[frontBank_q][rdAddr];
        rdBot_q <= memBot[frontBank_q][rdAddr];
      end
    end
  end

  assign rd_valid     = rdValid_q;
  assign rd_top       = rdTop_q;
  assign rd_bot       = rdBot_q;
  assign front_bank   = frontBank_q;
  assign swap_pending = swapPending_q;

endmodule

// File: tb/tb_frame_buffer_sink.sv
// Directed bench for frame_buffer_sink: a coordinate-level model of both
// banks runs alongside the DUT and is compared every cycle, plus literal
// checks at the interesting points of each scenario.
module tb_frame_buffer_sink;

  localparam int COLOR_W = 9;

  logic               clkIn = 1'b0;
  logic               rstN = 1'b0;
  logic               writeEn = 1'b0;
  logic [5:0]         writeX = '0;
  logic [5:0]         writeY = '0;
  logic [COLOR_W-1:0] writeColor = '0;
  logic               frameSync = 1'b0;
  logic               rdEn = 1'b0;
  logic [5:0]         rdX = '0;
  logic [4:0]         rdRow = '0;
  logic               rdValid;
  logic [COLOR_W-1:0] rdTop;
  logic [COLOR_W-1:0] rdBot;
  logic               frontBank;
  logic               swapPending;

  int compared = 0;
  int mismatched = 0;
  bit checkOn = 1'b0;

  frame_buffer_sink #(.COLOR_W(COLOR_W)) dut (
    .clk_in      (clkIn),
    .rst_n       (rstN),
    .write_en    (writeEn),
    .write_x     (writeX),
    .write_y     (writeY),
    .write_color (writeColor),
    .frame_sync  (frameSync),
    .rd_en       (rdEn),
    .rd_x        (rdX),
    .rd_row      (rdRow),
    .rd_valid    (rdValid),
    .rd_top      (rdTop),
    .rd_bot      (rdBot),
    .front_bank  (frontBank),
    .swap_pending(swapPending)
  );

  always #5 clkIn = ~clkIn;

  // Model: pixel images per bank indexed by (x,y), plus which pixels are known
  int memM [2][64][64];
  bit wrM  [2][64][64];
  bit frontM = 1'b0;
  bit pendM = 1'b0;
  bit validM = 1'b0;
  int topM = 0;
  int botM = 0;
  bit topKnownM = 1'b1;
  bit botKnownM = 1'b1;

  // Advance the model on each edge from the inputs the DUT sees
  always @(posedge clkIn or negedge rstN) begin : modelStep
    bit lastPixel;
    bit oldFront;
    if (!rstN) begin
      frontM = 1'b0;
      pendM = 1'b0;
      validM = 1'b0;
      topM = 0;
      botM = 0;
      topKnownM = 1'b1;
      botKnownM = 1'b1;
    end else begin
      oldFront = frontM;
      validM = rdEn;
      if (rdEn) begin
        topM = memM[oldFront][rdX][rdRow];
        topKnownM = wrM[oldFront][rdX][rdRow];
        botM = memM[oldFront][rdX][int'(rdRow) + 32];
        botKnownM = wrM[oldFront][rdX][int'(rdRow) + 32];
      end
      if (writeEn) begin
        memM[!oldFront][writeX][writeY] = int'(writeColor);
        wrM[!oldFront][writeX][writeY] = 1'b1;
      end
      lastPixel = writeEn && (writeX == 6'd63) && (writeY == 6'd63);
      if (frameSync && (pendM || lastPixel)) begin
        frontM = !oldFront;
        pendM = 1'b0;
      end else if (lastPixel) begin
        pendM = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clkIn) begin
    if (checkOn) begin
      checkOutput("cyc_front_bank", int'(frontBank), int'(frontM));
      checkOutput("cyc_swap_pending", int'(swapPending), int'(pendM));
      checkOutput("cyc_rd_valid", int'(rdValid), int'(validM));
      if (topKnownM) checkOutput("cyc_rd_top", int'(rdTop), topM);
      if (botKnownM) checkOutput("cyc_rd_bot", int'(rdBot), botM);
    end
  end

  // Drive one cycle of inputs, let the edge happen, return 1 time unit later
  task automatic applyStimulus(input bit we, input int x, input int y, input int color,
                               input bit fs, input bit re, input int rx, input int rrow);
    writeEn = we;
    writeX = 6'(x);
    writeY = 6'(y);
    writeColor = COLOR_W'(color);
    frameSync = fs;
    rdEn = re;
    rdX = 6'(rx);
    rdRow = 5'(rrow);
    @(posedge clkIn);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeFrame(input int pattern);
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        if (pattern == 0) applyStimulus(1, x, y, (x ^ y) & 'h1FF, 0, 0, 0, 0);
        else              applyStimulus(1, x, y, ((x * 3) + y) & 'h1FF, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    @(posedge clkIn);
    #1;
    checkOn = 1'b1;
    @(posedge clkIn);
    #1;
    checkOutput("reset_front_bank", int'(frontBank), 0);
    checkOutput("reset_swap_pending", int'(swapPending), 0);
    checkOutput("reset_rd_valid", int'(rdValid), 0);
    checkOutput("reset_rd_top", int'(rdTop), 0);
    checkOutput("reset_rd_bot", int'(rdBot), 0);
    rstN = 1'b1;

    // Full frame x^y into bank 1, then swap it to the front
    writeFrame(0);
    checkOutput("frame_done_pending", int'(swapPending), 1);
    checkOutput("frame_done_front", int'(frontBank), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("swap_front", int'(frontBank), 1);
    checkOutput("swap_pending_clear", int'(swapPending), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 3);
    checkOutput("read53_valid", int'(rdValid), 1);
    checkOutput("read53_top", int'(rdTop), 'h006);
    checkOutput("read53_bot", int'(rdBot), 'h026);
    idleCycle();
    checkOutput("idle_valid", int'(rdValid), 0);
    checkOutput("idle_top_hold", int'(rdTop), 'h006);

    // Sync with nothing pending leaves the banks alone
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("nopend_sync_front", int'(frontBank), 1);

    // Back-bank write is invisible to reads
    applyStimulus(1, 10, 10, 'h1C0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 10, 10);
    checkOutput("backwrite_top", int'(rdTop), 'h000);
    checkOutput("backwrite_bot", int'(rdBot), 'h020);

    // Last pixel coinciding with sync swaps immediately
    applyStimulus(1, 63, 63, 'h155, 1, 0, 0, 0);
    checkOutput("coinc_front", int'(frontBank), 0);
    checkOutput("coinc_pending", int'(swapPending), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 63, 31);
    checkOutput("coinc_read_valid", int'(rdValid), 1);
    checkOutput("coinc_read_bot", int'(rdBot), 'h155);

    // Get front=1 with a frame pending, then reset mid-read
    applyStimulus(1, 63, 63, 'h0AA, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 63, 63, 'h0BB, 0, 0, 0, 0);
    checkOutput("prereset_front", int'(frontBank), 1);
    checkOutput("prereset_pending", int'(swapPending), 1);
    rdEn = 1'b1;
    rdX = 6'd5;
    rdRow = 5'd3;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_front", int'(frontBank), 0);
    checkOutput("async_reset_pending", int'(swapPending), 0);
    checkOutput("async_reset_valid", int'(rdValid), 0);
    checkOutput("async_reset_top", int'(rdTop), 0);
    @(posedge clkIn);
    #1;
    rdEn = 1'b0;
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("postreset_sync_front", int'(frontBank), 0);
    checkOutput("postreset_sync_pending", int'(swapPending), 0);

    // New frame into bank 1, swap, then 64 back-to-back reads with writes
    writeFrame(1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("frame2_front", int'(frontBank), 1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, i, (i + 1) & 63, (i * 5) & 'h1FF, 0, 1, i, (i * 7) & 31);
      checkOutput("stream_valid", int'(rdValid), 1);
      checkOutput("stream_top", int'(rdTop), ((i * 3) + ((i * 7) & 31)) & 'h1FF);
      checkOutput("stream_bot", int'(rdBot), ((i * 3) + ((i * 7) & 31) + 32) & 'h1FF);
    end
    idleCycle();
    checkOutput("stream_end_valid", int'(rdValid), 0);
    checkOutput("stream_front_kept", int'(frontBank), 1);
    idleCycle();

    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
